// File: rtl/i2c_passthru_pkg.sv
// Shared definitions for the I2C pass-through open-drain mismatch checker.
package i2c_passthru_pkg;

  typedef enum logic [1:0] {
    ST_MATCH    = 2'd0,
    ST_WAIT     = 2'd1,
    ST_MISMATCH = 2'd2,
    ST_SU_WAIT  = 2'd3
  } ch_state_t;

endpackage

// File: rtl/i2c_passthru_od_mismatch_ch.sv
// One open-drain channel: settle/setup FSM with a reference-tick down-timer
// and a sticky mismatch flag.
module i2c_passthru_od_mismatch_ch
  import i2c_passthru_pkg::*;
#(
  parameter int F_REF_T_R   = 15,
  parameter int F_REF_T_SU  = 4,
  parameter int WIDTH_F_REF = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_ref,
  input  logic chg_out,
  input  logic chg_in,
  input  logic eq,
  input  logic clr_sticky,
  output logic mismatch,
  output logic t_su_good,
  output logic mismatch_sticky
);

  localparam logic [WIDTH_F_REF-1:0] LOAD_R  = WIDTH_F_REF'(F_REF_T_R);
  localparam logic [WIDTH_F_REF-1:0] LOAD_SU = WIDTH_F_REF'(F_REF_T_SU);

  ch_state_t state, next_state;
  logic [WIDTH_F_REF-1:0] timer, timer_next;
  logic load_r, load_su, counting, rise;

  always_comb begin
    next_state = state;
    load_r     = 1'b0;
    load_su    = 1'b0;
    case (state)
      ST_MATCH: begin
        if (chg_out) begin
          next_state = ST_WAIT;
          load_r     = 1'b1;
        end else if (chg_in && !eq) begin
          next_state = ST_MISMATCH;
        end
      end
      ST_WAIT: begin
        if (chg_out) begin
          next_state = ST_WAIT;
          load_r     = 1'b1;
        end else if (timer == '0) begin
          next_state = ST_MISMATCH;
        end else if (eq) begin
          next_state = ST_SU_WAIT;
          load_su    = 1'b1;
        end
      end
      ST_MISMATCH: begin
        if (eq) begin
          next_state = ST_SU_WAIT;
          load_su    = 1'b1;
        end
      end
      ST_SU_WAIT: begin
        if (chg_out) begin
          next_state = ST_WAIT;
          load_r     = 1'b1;
        end else if (!eq) begin
          next_state = ST_MISMATCH;
        end else if (timer == '0) begin
          next_state = ST_MATCH;
        end
      end
      default: next_state = ST_MATCH;
    endcase
  end

  // A load always beats a decrement; the count saturates at zero.
  assign counting = pulse_ref && (state == ST_WAIT || state == ST_SU_WAIT) && (timer != '0);

  always_comb begin
    timer_next = timer;
    if (load_r)
      timer_next = LOAD_R;
    else if (load_su)
      timer_next = LOAD_SU;
    else if (counting)
      timer_next = timer - 1'b1;
  end

  assign rise = (next_state == ST_MISMATCH) && !mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_MATCH;
      timer           <= '0;
      mismatch        <= 1'b0;
      t_su_good       <= 1'b1;
      mismatch_sticky <= 1'b0;
    end else begin
      state     <= next_state;
      timer     <= timer_next;
      mismatch  <= (next_state == ST_MISMATCH);
      t_su_good <= (next_state == ST_MATCH);
      if (rise)
        mismatch_sticky <= 1'b1;
      else if (clr_sticky)
        mismatch_sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/i2c_passthru_od_mismatch_mc.sv
// Multi-channel open-drain pad mismatch monitor: shared reference-edge detect
// and pad change detect, one checker per channel.
module i2c_passthru_od_mismatch_mc
  import i2c_passthru_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int F_REF_T_R   = 15,
  parameter int F_REF_T_SU  = 4,
  parameter int WIDTH_F_REF = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_f_ref,
  input  logic [N_CH-1:0] i_padin,
  input  logic [N_CH-1:0] i_padout,
  input  logic [N_CH-1:0] i_clr_sticky,
  output logic [N_CH-1:0] o_mismatch,
  output logic [N_CH-1:0] o_t_su_good,
  output logic [N_CH-1:0] o_mismatch_sticky,
  output logic            o_any_mismatch
);

  logic            f_ref_q;
  logic [N_CH-1:0] padin_q, padout_q;
  logic            pulse_ref;
  logic [N_CH-1:0] chg_out, chg_in, eq;

  // Pad copies reset to released (bus idle) so leaving reset on an idle bus is quiet.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      f_ref_q  <= 1'b0;
      padin_q  <= '1;
      padout_q <= '1;
    end else begin
      f_ref_q  <= i_f_ref;
      padin_q  <= i_padin;
      padout_q <= i_padout;
    end
  end

  assign pulse_ref = i_f_ref & ~f_ref_q;
  assign chg_out   = i_padout ^ padout_q;
  assign chg_in    = i_padin ^ padin_q;
  assign eq        = ~(i_padin ^ i_padout);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    i2c_passthru_od_mismatch_ch #(
      .F_REF_T_R   (F_REF_T_R),
      .F_REF_T_SU  (F_REF_T_SU),
      .WIDTH_F_REF (WIDTH_F_REF)
    ) u_ch (
      .clk             (i_clk),
      .rst_n           (i_rstn),
      .pulse_ref       (pulse_ref),
      .chg_out         (chg_out[g]),
      .chg_in          (chg_in[g]),
      .eq              (eq[g]),
      .clr_sticky      (i_clr_sticky[g]),
      .mismatch        (o_mismatch[g]),
      .t_su_good       (o_t_su_good[g]),
      .mismatch_sticky (o_mismatch_sticky[g])
    );
  end

  assign o_any_mismatch = |o_mismatch;

endmodule

// File: tb/tb_i2c_passthru_od_mismatch_mc.sv
// Randomized plus directed bench; a reference model predicts every cycle's
// outputs into a queue that a separate monitor drains and compares.
module tb_i2c_passthru_od_mismatch_mc;

  localparam int NCH  = 2;
  localparam int T_R  = 15;
  localparam int T_SU = 4;

  localparam int S_MATCH = 10, S_WAIT = 11, S_MIS = 12, S_SU = 13;

  logic clk = 1'b0;
  logic rstn;
  logic f_ref;
  logic [NCH-1:0] padin, padout, clr;
  logic [NCH-1:0] mismatch, t_su_good, sticky;
  logic any_mismatch;

  i2c_passthru_od_mismatch_mc #(
    .N_CH(NCH), .F_REF_T_R(T_R), .F_REF_T_SU(T_SU), .WIDTH_F_REF(4)
  ) dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_f_ref           (f_ref),
    .i_padin           (padin),
    .i_padout          (padout),
    .i_clr_sticky      (clr),
    .o_mismatch        (mismatch),
    .o_t_su_good       (t_su_good),
    .o_mismatch_sticky (sticky),
    .o_any_mismatch    (any_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] mm;
    logic [NCH-1:0] sg;
    logic [NCH-1:0] st;
    logic           any;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // model registers
  logic [NCH-1:0] m_pi_q, m_po_q, m_sticky;
  logic           m_fr_q;
  int             m_st[NCH];
  int             m_tm[NCH];

  logic [NCH-1:0] cur_pi, cur_po;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  task automatic modelReset();
    m_pi_q = '1;
    m_po_q = '1;
    m_fr_q = 1'b0;
    m_sticky = '0;
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = S_MATCH;
      m_tm[c] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs that will be sampled.
  task automatic modelStep(input logic [NCH-1:0] pi, input logic [NCH-1:0] po,
                           input logic fr, input logic [NCH-1:0] cl);
    bit pulse;
    pulse = fr && !m_fr_q;
    for (int c = 0; c < NCH; c++) begin
      bit co, ci, e;
      int ns, nt;
      co = (po[c] != m_po_q[c]);
      ci = (pi[c] != m_pi_q[c]);
      e  = (pi[c] == po[c]);
      ns = m_st[c];
      nt = m_tm[c];
      if (pulse && (m_st[c] == S_WAIT || m_st[c] == S_SU) && nt > 0) nt = nt - 1;
      if (m_st[c] == S_MATCH) begin
        if (co) begin ns = S_WAIT; nt = T_R; end
        else if (ci && !e) ns = S_MIS;
      end else if (m_st[c] == S_WAIT) begin
        if (co) nt = T_R;
        else if (m_tm[c] == 0) ns = S_MIS;
        else if (e) begin ns = S_SU; nt = T_SU; end
      end else if (m_st[c] == S_MIS) begin
        if (e) begin ns = S_SU; nt = T_SU; end
      end else begin
        if (co) begin ns = S_WAIT; nt = T_R; end
        else if (!e) ns = S_MIS;
        else if (m_tm[c] == 0) ns = S_MATCH;
      end
      if (ns == S_MIS && m_st[c] != S_MIS) m_sticky[c] = 1'b1;
      else if (cl[c]) m_sticky[c] = 1'b0;
      m_st[c] = ns;
      m_tm[c] = nt;
    end
    m_pi_q = pi;
    m_po_q = po;
    m_fr_q = fr;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the predicted outputs.
  task automatic applyStimulus(input logic [NCH-1:0] pi, input logic [NCH-1:0] po,
                               input logic fr, input logic [NCH-1:0] cl, input logic rn);
    exp_t e;
    @(negedge clk);
    padin = pi; padout = po; f_ref = fr; clr = cl; rstn = rn;
    cur_pi = pi; cur_po = po;
    if (!rn) modelReset();
    else modelStep(pi, po, fr, cl);
    for (int c = 0; c < NCH; c++) begin
      e.mm[c] = (m_st[c] == S_MIS);
      e.sg[c] = (m_st[c] == S_MATCH);
    end
    e.st  = m_sticky;
    e.any = |e.mm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(cur_pi, cur_po, 1'b0, '0, 1'b1);
  endtask

  task automatic refPulses(input int n);
    repeat (n) begin
      applyStimulus(cur_pi, cur_po, 1'b1, '0, 1'b1);
      applyStimulus(cur_pi, cur_po, 1'b0, '0, 1'b1);
    end
  endtask

  task automatic sampleAfterEdge();
    @(posedge clk);
    #1;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("sb_mismatch", 8'(mismatch), 8'(e.mm));
      checkOutput("sb_t_su_good", 8'(t_su_good), 8'(e.sg));
      checkOutput("sb_sticky", 8'(sticky), 8'(e.st));
      checkOutput("sb_any", 8'(any_mismatch), 8'(e.any));
    end
  end

  initial begin
    logic [NCH-1:0] pi, po, cl;
    logic fr, rn;
    bit follow;
    int k;
    padin = '1; padout = '1; f_ref = 1'b0; clr = '0; rstn = 1'b0;
    cur_pi = '1; cur_po = '1;
    modelReset();

    applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 1'b0);
    idle(100);
    sampleAfterEdge();
    checkOutput("idle_mismatch", 8'(mismatch), 8'h0);
    checkOutput("idle_t_su_good", 8'(t_su_good), 8'h3);
    checkOutput("idle_sticky", 8'(sticky), 8'h0);

    // ch0 released pad pulled low, input follows after three reference ticks
    applyStimulus(2'b11, 2'b10, 1'b0, 2'b00, 1'b1);
    refPulses(3);
    applyStimulus(2'b10, 2'b10, 1'b0, 2'b00, 1'b1);
    refPulses(3);
    sampleAfterEdge();
    checkOutput("su_not_yet", 8'(t_su_good[0]), 8'h0);
    refPulses(1);
    sampleAfterEdge();
    checkOutput("su_good_back", 8'(t_su_good[0]), 8'h1);
    checkOutput("su_no_mismatch", 8'(mismatch), 8'h0);
    applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 1'b1);
    refPulses(T_R);

    // ch1 driven low with input low, then released while input stays low
    applyStimulus(2'b01, 2'b01, 1'b0, 2'b00, 1'b1);
    refPulses(T_SU + 1);
    applyStimulus(2'b01, 2'b11, 1'b0, 2'b00, 1'b1);
    refPulses(T_R - 1);
    sampleAfterEdge();
    checkOutput("timeout_early", 8'(mismatch[1]), 8'h0);
    refPulses(1);
    sampleAfterEdge();
    checkOutput("timeout_mm", 8'(mismatch[1]), 8'h1);
    checkOutput("timeout_sticky", 8'(sticky[1]), 8'h1);
    checkOutput("timeout_any", 8'(any_mismatch), 8'h1);
    applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 1'b1);
    sampleAfterEdge();
    checkOutput("release_mm", 8'(mismatch[1]), 8'h0);
    checkOutput("release_sticky", 8'(sticky[1]), 8'h1);
    refPulses(T_SU);

    // sticky clear alone, then clear coinciding with a new rise
    applyStimulus(2'b11, 2'b11, 1'b0, 2'b10, 1'b1);
    sampleAfterEdge();
    checkOutput("clr_alone", 8'(sticky[1]), 8'h0);
    applyStimulus(2'b11, 2'b01, 1'b0, 2'b00, 1'b1);
    refPulses(T_R - 1);
    applyStimulus(2'b11, 2'b01, 1'b1, 2'b00, 1'b1);
    applyStimulus(2'b11, 2'b01, 1'b0, 2'b10, 1'b1);
    sampleAfterEdge();
    checkOutput("clr_rise_mm", 8'(mismatch[1]), 8'h1);
    checkOutput("clr_rise_sticky", 8'(sticky[1]), 8'h1);
    applyStimulus(2'b11, 2'b01, 1'b0, 2'b10, 1'b1);
    sampleAfterEdge();
    checkOutput("clr_later", 8'(sticky[1]), 8'h0);
    applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 1'b1);
    refPulses(T_SU + 1);

    // ch0 input glitches low while output released
    applyStimulus(2'b10, 2'b11, 1'b0, 2'b00, 1'b1);
    sampleAfterEdge();
    checkOutput("in_glitch_mm0", 8'(mismatch[0]), 8'h1);
    checkOutput("in_glitch_mm1", 8'(mismatch[1]), 8'h0);
    applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 1'b1);
    refPulses(T_SU + 1);

    // reset in the middle of a settle window
    applyStimulus(2'b11, 2'b10, 1'b0, 2'b00, 1'b1);
    refPulses(10);
    applyStimulus(2'b11, 2'b10, 1'b0, 2'b00, 1'b0);
    #1;
    checkOutput("async_mm", 8'(mismatch), 8'h0);
    checkOutput("async_su", 8'(t_su_good), 8'h3);
    checkOutput("async_sticky", 8'(sticky), 8'h0);
    checkOutput("async_any", 8'(any_mismatch), 8'h0);
    applyStimulus(2'b11, 2'b10, 1'b0, 2'b00, 1'b1);
    refPulses(T_R - 1);
    sampleAfterEdge();
    checkOutput("post_rst_early", 8'(mismatch[0]), 8'h0);
    refPulses(1);
    sampleAfterEdge();
    checkOutput("post_rst_mm", 8'(mismatch[0]), 8'h1);
    applyStimulus(2'b11, 2'b11, 1'b0, 2'b00, 1'b1);
    refPulses(T_SU + 1);

    // randomized traffic: segments where the input either tracks or ignores the output
    for (int s = 0; s < 6; s++) begin
      follow = (s % 3) != 2;
      k = $urandom_range(2, 6);
      for (int c = 0; c < 250; c++) begin
        po = cur_po;
        pi = cur_pi;
        cl = '0;
        for (int ch = 0; ch < NCH; ch++) begin
          if ($urandom_range(0, 29) == 0) po[ch] = ~po[ch];
          if (follow && $urandom_range(0, 3) == 0) pi[ch] = po[ch];
          if ($urandom_range(0, 79) == 0) pi[ch] = ~pi[ch];
          if ($urandom_range(0, 24) == 0) cl[ch] = 1'b1;
        end
        fr = (c % k) < (k / 2);
        rn = ($urandom_range(0, 499) != 0);
        applyStimulus(pi, po, fr, cl, rn);
      end
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_passthru_od_mismatch_mc.md
I2C_PASSTHRU_OD_MISMATCH_MC -- requirements
Module: i2c_passthru_od_mismatch_mc

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent open-drain channels (1..8).
REQ-002 SHALL have parameter F_REF_T_R, default 15, i_f_ref rising edges allowed for a driven level to settle before mismatch (>=2).
REQ-003 SHALL have parameter F_REF_T_SU, default 4, i_f_ref rising edges of stable match required before setup is reported good (>=2).
REQ-004 SHALL have parameter WIDTH_F_REF, default 4, timer width, ceil(log2(max(F_REF_T_R,F_REF_T_SU)+1)).
REQ-005 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 i_rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 i_f_ref  in  1  slow reference, synchronous to i_clk, sampled for rising edges.
REQ-008 i_padin  in  N_CH  per-channel level seen at pad input.
REQ-009 i_padout  in  N_CH  per-channel level driven by FPGA (1 = released).
REQ-010 i_clr_sticky  in  N_CH  per-channel clear of sticky flag.
REQ-011 o_mismatch  out  N_CH  per-channel live mismatch.
REQ-012 o_t_su_good  out  N_CH  per-channel data setup time satisfied.
REQ-013 o_mismatch_sticky  out  N_CH  per-channel latched mismatch history.
REQ-014 o_any_mismatch  out  1  OR-reduction of o_mismatch.

Function
REQ-015 pulse_ref SHALL be 1 for one i_clk cycle when i_f_ref is 1 and its registered copy is 0; shared by all channels.
REQ-016 Per channel, chg_out / chg_in SHALL be 1 when i_padout / i_padin differ from their registered copies; eq SHALL be (i_padin == i_padout).
REQ-017 Each channel SHALL run an FSM with states MATCH, WAIT, MISMATCH, SU_WAIT and one WIDTH_F_REF-bit down-timer.
REQ-018 MATCH: chg_out -> WAIT, load timer F_REF_T_R; else chg_in and not eq -> MISMATCH.
REQ-019 WAIT: chg_out -> stay WAIT, reload F_REF_T_R; else timer==0 -> MISMATCH; else eq -> SU_WAIT, load F_REF_T_SU.
REQ-020 MISMATCH: eq -> SU_WAIT, load F_REF_T_SU; else stay.
REQ-021 SU_WAIT: chg_out -> WAIT, load F_REF_T_R; else not eq -> MISMATCH; else timer==0 -> MATCH.
REQ-022 Timer SHALL decrement by 1 on pulse_ref in WAIT and SU_WAIT, saturate at 0, and hold otherwise; a load in the same cycle wins over decrement.
REQ-023 o_mismatch SHALL be registered, 1 exactly while state is MISMATCH; o_t_su_good SHALL be registered, 1 exactly while state is MATCH.
REQ-024 Detection latency from the i_padout change that is never followed by eq: mismatch asserted on the cycle after the F_REF_T_R-th pulse_ref counted in WAIT.
REQ-025 o_mismatch_sticky SHALL set on the cycle o_mismatch rises, clear on i_clr_sticky; set wins when simultaneous.
REQ-026 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.
REQ-027 Unreachable state encodings SHALL return to MATCH on the next cycle.

Reset
REQ-028 While i_rstn=0: state MATCH, timer 0, o_mismatch 0, o_t_su_good all 1, o_mismatch_sticky 0, o_any_mismatch 0.
REQ-029 Registered copies of i_padin, i_padout SHALL reset to all-1 (bus idle), i_f_ref copy to 0; reset mid-operation discards any timer progress.

Structure
REQ-030 State encodings (MATCH=0, WAIT=1, MISMATCH=2, SU_WAIT=3) SHALL live in shared package i2c_passthru_pkg.
REQ-031 Per-channel FSM, timer and sticky flag SHALL be sub-module i2c_passthru_od_mismatch_ch, instantiated N_CH times via generate; pulse_ref is generated once at top.

Verification
REQ-032 Reset, pads 1/1, no activity 100 cycles -> o_mismatch=0, o_t_su_good=all 1, sticky=0.
REQ-033 Ch0 padout 1->0, padin follows after 3 pulse_ref -> no mismatch; o_t_su_good[0] returns 1 after 4 further pulse_ref.
REQ-034 Ch1 padout 0->1, padin held 0 (defaults) -> o_mismatch[1]=1 one cycle after 15th pulse_ref, sticky[1]=1, o_any_mismatch=1; release padin -> o_mismatch[1]=0 next cycle, sticky stays 1.
REQ-035 Ch0 in MATCH, padin 1->0 with padout 1 -> o_mismatch[0]=1 next cycle; ch1 unaffected.
REQ-036 i_clr_sticky[1] pulsed same cycle o_mismatch[1] rises -> sticky[1]=1; later pulse alone -> 0.
REQ-037 i_rstn low during WAIT with 10 pulses counted -> all outputs at reset values asynchronously; after release, 15 full pulses needed for mismatch.
